// File: rtl/memory_bus_arbiter_pkg.sv
// Shared types and helpers for the external memory pad arbiter.
package memory_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    // pad_data_size encoding
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b11;

    // Also flags the unused size code 10, so one test covers every reject.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return addr_lo[0];
            SIZE_WORD: return addr_lo != 2'b00;
            default:   return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/memory_bus_arbiter_rr_priority_picker.sv
// Combinational requester picker: round-robin after last_grant, or lowest index when fixed.
module rr_priority_picker #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    input  logic          fixed,
    output logic [IW-1:0] index,
    output logic          any
);

    logic [IW-1:0] cand;
    logic          found;

    // Fixed priority is a round-robin scan that always starts just after N-1.
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        index = '0;
        found = 1'b0;
        any   = |req;
        cand  = fixed ? IW'(N - 1) : last_grant;
        for (int i = 0; i < N; i++) begin
            cand = (cand == IW'(N - 1)) ? '0 : cand + 1'b1;
            if (req[cand] && !found) begin
                index = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/memory_bus_arbiter.sv
// Arbitrates NUM_MASTERS req/ack requesters onto the single external memory pad port.
// Optional access timeout: define MEMORY_BUS_ARBITER_TIMEOUT_EN.
module memory_bus_arbiter
    import memory_bus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int FIXED_PRIORITY = 0,
    parameter int TIMEOUT_CYCLES = 255,
    localparam int IW            = $clog2(NUM_MASTERS)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_MASTERS-1:0]    m_req,
    input  logic [NUM_MASTERS-1:0]    m_write,
    input  logic [2*NUM_MASTERS-1:0]  m_size,
    input  logic [32*NUM_MASTERS-1:0] m_addr,
    input  logic [32*NUM_MASTERS-1:0] m_wdata,
    output logic [NUM_MASTERS-1:0]    m_ack,
    output logic [NUM_MASTERS-1:0]    m_err,
    output logic [31:0]               m_rdata,
    output logic                      grant_valid,
    output logic [IW-1:0]             grant_id,
    output logic                      mem_req,
    output logic                      mem_write,
    output logic [1:0]                mem_size,
    output logic [31:0]               mem_addr,
    output logic [31:0]               mem_wdata,
    input  logic [31:0]               mem_rdata,
    input  logic                      mem_ready
);

    if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("memory_bus_arbiter: unsupported parameter set");
    end

    arb_state_e    state_q, state_d;
    logic [IW-1:0] last_grant_q, last_grant_d;
    logic [IW-1:0] grant_id_q, grant_id_d;
    logic          grant_valid_q, grant_valid_d;
    logic          write_q, write_d;
    logic [1:0]    size_q, size_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          err_q, err_d;
    logic [31:0]   rdata_q, rdata_d;

    logic [IW-1:0] pick_index;
    logic          pick_any;
    logic          sel_write;
    logic [1:0]    sel_size;
    logic [31:0]   sel_addr;
    logic [31:0]   sel_wdata;
    logic          tmo_hit;

    rr_priority_picker #(
        .N  (NUM_MASTERS),
        .IW (IW)
    ) u_picker (
        .req        (m_req),
        .last_grant (last_grant_q),
        .fixed      (FIXED_PRIORITY != 0),
        .index      (pick_index),
        .any        (pick_any)
    );

    always_comb begin
        sel_write = 1'b0;
        sel_size  = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (pick_index == IW'(i)) begin
                sel_write = m_write[i];
                sel_size  = m_size[2*i +: 2];
                sel_addr  = m_addr[32*i +: 32];
                sel_wdata = m_wdata[32*i +: 32];
            end
        end
    end

`ifdef MEMORY_BUS_ARBITER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

    // Counter sits at zero outside ACCESS, so it is already clear on entry.
    always_comb begin
        tmo_cnt_d = '0;
        if (state_q == ACCESS && !mem_ready) tmo_cnt_d = tmo_cnt_q + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) tmo_cnt_q <= '0;
        else       tmo_cnt_q <= tmo_cnt_d;
    end

    assign tmo_hit = (state_q == ACCESS) && !mem_ready && (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        grant_id_d    = grant_id_q;
        grant_valid_d = grant_valid_q;
        write_d       = write_q;
        size_d        = size_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        err_d         = err_q;
        rdata_d       = rdata_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    last_grant_d  = pick_index;
                    grant_id_d    = pick_index;
                    grant_valid_d = 1'b1;
                    write_d       = sel_write;
                    size_d        = sel_size;
                    addr_d        = sel_addr;
                    wdata_d       = sel_wdata;
                    if (is_misaligned(sel_size, sel_addr[1:0])) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (mem_ready) begin
                    rdata_d = write_q ? 32'd0 : mem_rdata;
                    state_d = RESP;
                end else if (tmo_hit) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                grant_valid_d = 1'b0;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the datapath latches are reset too, so every pad-facing output reads 0 out of reset.
    // NOTE: state is updated with non-blocking assignments only.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            last_grant_q  <= IW'(NUM_MASTERS - 1);
            grant_id_q    <= '0;
            grant_valid_q <= 1'b0;
            write_q       <= 1'b0;
            size_q        <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            err_q         <= 1'b0;
            rdata_q       <= '0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            grant_id_q    <= grant_id_d;
            grant_valid_q <= grant_valid_d;
            write_q       <= write_d;
            size_q        <= size_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            err_q         <= err_d;
            rdata_q       <= rdata_d;
        end
    end

    always_comb begin
        m_ack = '0;
        m_err = '0;
        if (state_q == RESP) begin
            m_ack[grant_id_q] = 1'b1;
            m_err[grant_id_q] = err_q;
        end
    end

    assign m_rdata     = rdata_q;
    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;
    assign mem_req     = (state_q == ACCESS);
    assign mem_write   = write_q;
    assign mem_size    = size_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Self-checking bench: a round-robin and a fixed-priority arbiter share one stimulus,
// checked against a transaction-level reference model.
module tb_memory_bus_arbiter;

    localparam int N   = 3;
    localparam int IW  = $clog2(N);
    localparam int TMO = 4;

    logic            clock = 1'b0;
    logic            reset;
    logic [N-1:0]    m_req, m_write;
    logic [2*N-1:0]  m_size;
    logic [32*N-1:0] m_addr, m_wdata;
    logic [31:0]     mem_rdata;
    logic            mem_ready;

    logic [N-1:0]  rr_ack, rr_err, fp_ack, fp_err;
    logic [31:0]   rr_rdata, fp_rdata, rr_maddr, fp_maddr, rr_mwdata, fp_mwdata;
    logic          rr_gv, fp_gv, rr_mreq, fp_mreq, rr_mwrite, fp_mwrite;
    logic [IW-1:0] rr_gid, fp_gid;
    logic [1:0]    rr_msize, fp_msize;

    always #5 clock = ~clock;

    memory_bus_arbiter #(.NUM_MASTERS(N), .FIXED_PRIORITY(0), .TIMEOUT_CYCLES(TMO)) u_rr (
        .clock(clock), .reset(reset), .m_req(m_req), .m_write(m_write), .m_size(m_size),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_ack(rr_ack), .m_err(rr_err), .m_rdata(rr_rdata),
        .grant_valid(rr_gv), .grant_id(rr_gid), .mem_req(rr_mreq), .mem_write(rr_mwrite),
        .mem_size(rr_msize), .mem_addr(rr_maddr), .mem_wdata(rr_mwdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready));

    memory_bus_arbiter #(.NUM_MASTERS(N), .FIXED_PRIORITY(1), .TIMEOUT_CYCLES(TMO)) u_fp (
        .clock(clock), .reset(reset), .m_req(m_req), .m_write(m_write), .m_size(m_size),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_ack(fp_ack), .m_err(fp_err), .m_rdata(fp_rdata),
        .grant_valid(fp_gv), .grant_id(fp_gid), .mem_req(fp_mreq), .mem_write(fp_mwrite),
        .mem_size(fp_msize), .mem_addr(fp_maddr), .mem_wdata(fp_mwdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready));

    // Outputs of whichever instance the current section is checking.
    logic          sel_fp;
    logic [N-1:0]  obs_ack, obs_err;
    logic [31:0]   obs_rdata, obs_maddr, obs_mwdata;
    logic          obs_gv, obs_mreq, obs_mwrite;
    logic [IW-1:0] obs_gid;
    logic [1:0]    obs_msize;
    assign obs_ack    = sel_fp ? fp_ack    : rr_ack;
    assign obs_err    = sel_fp ? fp_err    : rr_err;
    assign obs_rdata  = sel_fp ? fp_rdata  : rr_rdata;
    assign obs_maddr  = sel_fp ? fp_maddr  : rr_maddr;
    assign obs_mwdata = sel_fp ? fp_mwdata : rr_mwdata;
    assign obs_gv     = sel_fp ? fp_gv     : rr_gv;
    assign obs_mreq   = sel_fp ? fp_mreq   : rr_mreq;
    assign obs_mwrite = sel_fp ? fp_mwrite : rr_mwrite;
    assign obs_gid    = sel_fp ? fp_gid    : rr_gid;
    assign obs_msize  = sel_fp ? fp_msize  : rr_msize;

    int n_checks = 0;
    int n_fail   = 0;
    int last;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_pick(input logic [N-1:0] req, input int last_id, input bit fixed);
        if (fixed) begin
            for (int i = 0; i < N; i++) if (req[i]) return i;
        end else begin
            for (int off = 1; off <= N; off++) if (req[(last_id + off) % N]) return (last_id + off) % N;
        end
        return 0;
    endfunction

    function automatic bit model_bad(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'b10) return 1'b1;
        if (sz == 2'b01) return a[0];
        if (sz == 2'b11) return a[1:0] != 2'b00;
        return 1'b0;
    endfunction

    task automatic raise(input int m, input bit w, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] d);
        m_req[m]           = 1'b1;
        m_write[m]         = w;
        m_size[2*m +: 2]   = sz;
        m_addr[32*m +: 32] = a;
        m_wdata[32*m +: 32] = d;
    endtask

    task automatic raise_random(input int m);
        logic [1:0]  sz;
        logic [31:0] a;
        int          r;
        if (!m_req[m]) begin
            r  = $urandom_range(0, 7);
            sz = (r < 2) ? 2'b00 : (r < 4) ? 2'b01 : (r < 7) ? 2'b11 : 2'b10;
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            raise(m, 1'($urandom_range(0, 1)), sz, a, $urandom);
        end
    endtask

    task automatic reset_dut();
        reset     = 1'b1;
        m_req     = '0;
        mem_ready = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        last  = N - 1;
    endtask

    // Entered at the negedge of an IDLE cycle with m_req set; leaves at the negedge of the next IDLE cycle.
    task automatic do_round(input int k, input logic [31:0] rd, input bit noise);
        int          w;
        bit          bad;
        logic        ew;
        logic [1:0]  esz;
        logic [31:0] ea, ed, erd;
        w   = model_pick(m_req, last, sel_fp);
        ew  = m_write[w];
        esz = m_size[2*w +: 2];
        ea  = m_addr[32*w +: 32];
        ed  = m_wdata[32*w +: 32];
        bad = model_bad(esz, ea);
        mem_ready = 1'b1;
        mem_rdata = $urandom;
        if (!bad) begin
            for (int c = 1; c <= k; c++) begin
                @(negedge clock);
                check("access.mem_req", 32'(obs_mreq), 32'd1);
                check("access.grant_valid", 32'(obs_gv), 32'd1);
                check("access.grant_id", 32'(obs_gid), 32'(w));
                check("access.no_ack", 32'(obs_ack), 32'd0);
                check("access.mem_addr", obs_maddr, ea);
                check("access.mem_wdata", obs_mwdata, ed);
                check("access.mem_write", 32'(obs_mwrite), 32'(ew));
                check("access.mem_size", 32'(obs_msize), 32'(esz));
                m_addr[32*w +: 32]  = $urandom;
                m_wdata[32*w +: 32] = $urandom;
                m_size[2*w +: 2]    = 2'($urandom);
                m_write[w]          = ~m_write[w];
                mem_ready = (c == k);
                mem_rdata = (c == k) ? rd : $urandom;
                if (noise) raise_random($urandom_range(0, N - 1));
            end
        end
        @(negedge clock);
        check("resp.ack", 32'(obs_ack), 32'd1 << w);
        check("resp.err", 32'(obs_err), bad ? (32'd1 << w) : 32'd0);
        check("resp.grant_valid", 32'(obs_gv), 32'd1);
        check("resp.grant_id", 32'(obs_gid), 32'(w));
        check("resp.mem_req", 32'(obs_mreq), 32'd0);
        erd = ew ? 32'd0 : rd;
        if (!bad) check("resp.rdata", obs_rdata, erd);
        m_req[w]  = 1'b0;
        mem_ready = 1'b1;
        @(negedge clock);
        check("idle.ack", 32'(obs_ack), 32'd0);
        check("idle.grant_valid", 32'(obs_gv), 32'd0);
        check("idle.mem_req", 32'(obs_mreq), 32'd0);
        if (!bad) check("idle.rdata_held", obs_rdata, erd);
        mem_ready = 1'b0;
        last = w;
    endtask

    initial begin
        sel_fp    = 1'b0;
        m_write   = '0;
        m_size    = '0;
        m_addr    = '0;
        m_wdata   = '0;
        mem_rdata = '0;
        reset_dut();

        check("rst.rr_ack", 32'(rr_ack), 32'd0);
        check("rst.rr_err", 32'(rr_err), 32'd0);
        check("rst.rr_rdata", rr_rdata, 32'd0);
        check("rst.rr_gv", 32'(rr_gv), 32'd0);
        check("rst.rr_gid", 32'(rr_gid), 32'd0);
        check("rst.rr_mem_req", 32'(rr_mreq), 32'd0);
        check("rst.rr_mem_fields", {rr_maddr[31:3], rr_mwrite, rr_msize} | rr_mwdata, 32'd0);
        check("rst.fp_gv", 32'(fp_gv), 32'd0);
        check("rst.fp_mem_req", 32'(fp_mreq), 32'd0);
        check("rst.fp_ack", 32'(fp_ack), 32'd0);

        // mem_ready with nobody requesting must leave the arbiter idle.
        mem_ready = 1'b1;
        @(negedge clock);
        check("idle_noreq.gv", 32'(rr_gv), 32'd0);
        check("idle_noreq.mem_req", 32'(rr_mreq), 32'd0);
        check("idle_noreq.ack", 32'(rr_ack), 32'd0);
        mem_ready = 1'b0;

        // Directed: word load, half store misaligned, illegal size, odd-address byte.
        raise(0, 1'b0, 2'b11, 32'h0000_0100, 32'h0);
        do_round(2, 32'h1234_5678, 1'b0);
        raise(1, 1'b1, 2'b01, 32'h0000_0203, 32'hDEAD_BEEF);
        do_round(1, 32'h0, 1'b0);
        raise(2, 1'b0, 2'b10, 32'h0000_0040, 32'h0);
        do_round(1, 32'h0, 1'b0);
        raise(2, 1'b0, 2'b00, 32'h0000_0043, 32'h0);
        do_round(1, 32'hA5A5_0042, 1'b0);
        raise(1, 1'b1, 2'b11, 32'h0000_0202, 32'h0);
        do_round(1, 32'h0, 1'b0);

        // Two masters requesting continuously, memory always ready: expect 0,1,0,1.
        for (int r = 0; r < 4; r++) begin
            raise_random(0);
            raise(0, 1'b0, 2'b11, 32'h1000 + 32'(r * 4), 32'h0);
            raise(1, 1'b0, 2'b11, 32'h2000 + 32'(r * 4), 32'h0);
            check("rr.alternate", 32'(model_pick(m_req, last, 1'b0)), 32'(r % 2));
            do_round(1, $urandom, 1'b0);
        end

        // Fixed priority: master 0 wins every time while master 1 waits.
        reset_dut();
        sel_fp = 1'b1;
        for (int r = 0; r < 4; r++) begin
            raise(0, 1'b0, 2'b11, 32'h3000 + 32'(r * 4), 32'h0);
            raise(1, 1'b1, 2'b11, 32'h4000, 32'h55);
            do_round(1, $urandom, 1'b0);
        end
        check("fp.m1_still_waiting", 32'(fp_ack), 32'd0);
        for (int r = 0; r < 20; r++) begin
            if (m_req == '0) raise_random($urandom_range(0, N - 1));
            do_round($urandom_range(1, TMO), $urandom, 1'b1);
        end

        // Randomized round-robin traffic with late-arriving requests.
        reset_dut();
        sel_fp = 1'b0;
        for (int r = 0; r < 40; r++) begin
            if (m_req == '0) begin
                if ($urandom_range(0, 3) == 0) begin
                    @(negedge clock);
                    check("rand.idle_gv", 32'(obs_gv), 32'd0);
                end
                raise_random($urandom_range(0, N - 1));
            end
            if ($urandom_range(0, 1) == 1) raise_random($urandom_range(0, N - 1));
            do_round($urandom_range(1, TMO), $urandom, 1'b1);
        end

        // Reset during ACCESS: access dropped, no ack, master 0 wins first afterwards.
        reset_dut();
        raise(0, 1'b0, 2'b11, 32'h0000_0080, 32'h0);
        @(negedge clock);
        check("rstmid.mem_req_before", 32'(obs_mreq), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        check("rstmid.mem_req", 32'(obs_mreq), 32'd0);
        check("rstmid.ack", 32'(obs_ack), 32'd0);
        check("rstmid.gv", 32'(obs_gv), 32'd0);
        reset = 1'b0;
        last  = N - 1;
        raise(1, 1'b0, 2'b11, 32'h0000_0090, 32'h0);
        check("rstmid.first_winner", 32'(model_pick(m_req, last, 1'b0)), 32'd0);
        do_round(1, 32'hCAFE_0001, 1'b0);
        do_round(2, 32'hCAFE_0002, 1'b0);

`ifdef MEMORY_BUS_ARBITER_TIMEOUT_EN
        // No mem_ready: exactly TMO ACCESS cycles, then an error ack with zero data.
        raise(0, 1'b0, 2'b11, 32'h0000_0500, 32'h0);
        mem_ready = 1'b0;
        for (int c = 1; c <= TMO; c++) begin
            @(negedge clock);
            check("tmo.mem_req", 32'(obs_mreq), 32'd1);
            check("tmo.no_ack", 32'(obs_ack), 32'd0);
            mem_rdata = $urandom;
        end
        @(negedge clock);
        check("tmo.ack", 32'(obs_ack), 32'd1);
        check("tmo.err", 32'(obs_err), 32'd1);
        check("tmo.rdata", obs_rdata, 32'd0);
        check("tmo.mem_req_dropped", 32'(obs_mreq), 32'd0);
        m_req[0] = 1'b0;
        @(negedge clock);
        check("tmo.idle_gv", 32'(obs_gv), 32'd0);
        last = 0;
        // mem_ready on the timeout cycle wins.
        raise(1, 1'b0, 2'b11, 32'h0000_0600, 32'h0);
        do_round(TMO, 32'hBEEF_0004, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_bus_arbiter.md
Name: memory_bus_arbiter

Overview:
Shares the core's single external memory pad port between NUM_MASTERS requesters, for example the instruction/data pad path and a debug/DMA master. Each requester uses a req/ack handshake. The arbiter grants one requester at a time, round-robin or fixed-priority, and latches that requester's transaction. It drives the memory port until mem_ready, then returns read data and status. It sits between the core pad outputs and the memory/pad ring.

Parameters:
NUM_MASTERS, 2, number of requesters (2..8); master 0 is the core.
FIXED_PRIORITY, 0, 1 = lowest index always wins; 0 = round-robin.
TIMEOUT_CYCLES, 255, ACCESS cycles before abort (used only with the optional feature).

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
m_req  in  NUM_MASTERS  per-master request; held until the matching m_ack
m_write  in  NUM_MASTERS  1 = store, 0 = load
m_size  in  2*NUM_MASTERS  per-master size: 00 byte, 01 half, 11 word (pad_data_size encoding)
m_addr  in  32*NUM_MASTERS  per-master byte address
m_wdata  in  32*NUM_MASTERS  per-master write data
m_ack  out  NUM_MASTERS  one-cycle completion pulse, one-hot
m_err  out  NUM_MASTERS  error flag, valid with m_ack
m_rdata  out  32  read data, shared by all masters, valid with m_ack
grant_valid  out  1  a transaction is owned
grant_id  out  $clog2(NUM_MASTERS)  index of the current owner
mem_req  out  1  memory access strobe
mem_write  out  1  latched write flag
mem_size  out  2  latched size
mem_addr  out  32  latched address
mem_wdata  out  32  latched write data
mem_rdata  in  32  memory read data
mem_ready  in  1  memory completes the access this cycle

Behaviour:
- Reset values: all outputs 0; state IDLE; last_grant = NUM_MASTERS-1, so master 0 wins first.
- Reset mid-operation: mem_req drops at that edge; the in-flight transaction is lost; no ack is issued.
- States: IDLE, ACCESS, RESP.
- IDLE, no m_req bits set: stay in IDLE; grant_valid=0.
- IDLE, any m_req bit set, round-robin: pick the first set bit searching from last_grant+1 with wrap-around mod NUM_MASTERS.
- IDLE, any m_req bit set, FIXED_PRIORITY=1: pick the lowest set index.
- On a grant: latch write/size/addr/wdata; set grant_id and grant_valid; update last_grant.
- Alignment check on grant: half with addr[0]=1, or word with addr[1:0]!=00, is misaligned. Size 10 is illegal.
- Misaligned or illegal request: go to RESP with err=1; no memory access.
- Legal request: go to ACCESS.
- ACCESS: mem_req=1 with the latched fields, stable throughout.
- mem_ready sampled high in ACCESS: capture mem_rdata (writes capture 0); mem_req=0 next cycle; go to RESP.
- RESP: m_ack[grant_id]=1 and m_err as set, for exactly one cycle; m_rdata is held until the next RESP. Then go to IDLE with grant_valid=0.
- Latency, legal access: grant edge, then ACCESS for k≥1 cycles, then RESP. Minimum 3 cycles from req sampled to ack. Back-to-back grants are separated by one IDLE cycle.
- m_req may still be high during the ack cycle. It is only sampled in IDLE, so a requester that deasserts after seeing ack is not re-granted.
- Requests changing while ungranted have no effect. Inputs from the granted master are ignored after the latch.
- mem_ready outside ACCESS is ignored.

Optional Feature:
MEMORY_BUS_ARBITER_TIMEOUT_EN.
- Defined: a counter clears on entry to ACCESS and increments each ACCESS cycle without mem_ready. When the count reaches TIMEOUT_CYCLES, mem_req drops, m_rdata=0, and the arbiter goes to RESP with err=1. mem_ready on the same cycle as the timeout wins, so the access completes normally.
- Undefined: no counter; ACCESS waits indefinitely; TIMEOUT_CYCLES is unused.

Decomposition:
- Package memory_bus_arbiter_pkg holds:
  - state enum {IDLE, ACCESS, RESP};
  - size constants SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b11;
  - function is_misaligned(size, addr[1:0]).
- One sub-module, rr_priority_picker: combinational; inputs req vector, last_grant, fixed flag; outputs index and any.

Test Plan:
- Single master 0 word load to 0x100, mem_ready on the 2nd ACCESS cycle, mem_rdata=0x12345678 → m_ack[0] exactly 4 cycles after req; m_rdata=0x12345678; m_err=0.
- Both masters requesting continuously, mem_ready always 1, round-robin → grants alternate 0,1,0,1; each ack is one cycle with no overlap.
- FIXED_PRIORITY=1, both requesting for 4 transactions → master 0 gets all 4; master 1 waits.
- Master 1 half store to 0x203 → m_ack[1] and m_err[1]=1; mem_req never asserts.
- Reset asserted mid-ACCESS → mem_req=0 the next cycle; no ack; master 0 wins the first arbitration after reset.
- With MEMORY_BUS_ARBITER_TIMEOUT_EN and TIMEOUT_CYCLES=4, mem_ready held 0 → m_ack with m_err=1, m_rdata=0; mem_req high for exactly 4 cycles.
